// File: rtl/legv8_mc_control_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control sequencer: states,
// instruction classes, ALU op codes, mux selects and opcode patterns.
package legv8_mc_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE = 4'd0,
    CLS_ADD  = 4'd1,
    CLS_SUB  = 4'd2,
    CLS_AND  = 4'd3,
    CLS_ORR  = 4'd4,
    CLS_LDUR = 4'd5,
    CLS_STUR = 4'd6,
    CLS_CBZ  = 4'd7,
    CLS_CBNZ = 4'd8,
    CLS_B    = 4'd9
  } iclass_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CBZ  = 4'b0111;
  localparam logic [3:0] ALU_B    = 4'b1000;
  localparam logic [3:0] ALU_CBNZ = 4'b1001;

  localparam logic [1:0] PC_SRC_PC4 = 2'd0;
  localparam logic [1:0] PC_SRC_ALU = 2'd1;
  localparam logic [1:0] PC_SRC_BR  = 2'd2;

  localparam logic [1:0] SRC_B_REG = 2'd0;
  localparam logic [1:0] SRC_B_IMM = 2'd1;
  localparam logic [1:0] SRC_B_BR  = 2'd2;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  // Branch opcodes only fix their upper bits; the rest belongs to the offset.
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_PFX = 8'b10110101;
  localparam logic [5:0]  OP_B_PFX    = 6'b000101;

  function automatic logic is_rtype(input iclass_t c);
    return (c == CLS_ADD) || (c == CLS_SUB) || (c == CLS_AND) || (c == CLS_ORR);
  endfunction

  function automatic logic is_branch(input iclass_t c);
    return (c == CLS_CBZ) || (c == CLS_CBNZ) || (c == CLS_B);
  endfunction

  function automatic logic [3:0] rtype_alu_op(input iclass_t c);
    case (c)
      CLS_ADD: return ALU_ADD;
      CLS_SUB: return ALU_SUB;
      CLS_ORR: return ALU_ORR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/legv8_op_decode.sv
// Combinational opcode field to instruction class decode; flags any opcode
// that matches none of the supported LEGv8 patterns.
module legv8_op_decode
  import legv8_mc_control_pkg::*;
(
  input  logic [10:0] i_opcode,
  output iclass_t     o_class,
  output logic        o_illegal
);

  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    if (i_opcode == OP_ADD)                 o_class = CLS_ADD;
    else if (i_opcode == OP_SUB)            o_class = CLS_SUB;
    else if (i_opcode == OP_AND)            o_class = CLS_AND;
    else if (i_opcode == OP_ORR)            o_class = CLS_ORR;
    else if (i_opcode == OP_LDUR)           o_class = CLS_LDUR;
    else if (i_opcode == OP_STUR)           o_class = CLS_STUR;
    else if (i_opcode[10:3] == OP_CBZ_PFX)  o_class = CLS_CBZ;
    else if (i_opcode[10:3] == OP_CBNZ_PFX) o_class = CLS_CBNZ;
    else if (i_opcode[10:5] == OP_B_PFX)    o_class = CLS_B;
    else                                    o_illegal = 1'b1;
  end

endmodule

// File: rtl/legv8_mc_control.sv
// LEGv8 multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define LEGV8_PERF_CNT_EN to add the cycle/retire performance counters.
module legv8_mc_control
  import legv8_mc_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [10:0]      opcode,
  input  logic             rt_zero,
  input  logic             mem_ack,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state_o
`ifdef LEGV8_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retire_count
`endif
);

  // Memory handshake: mem_read/mem_write is a request level that stays up
  // from entry into FETCH/MEM through the cycle mem_ack is seen, inclusive;
  // the state advances on that edge so the request drops the next cycle.

  state_t  r_state;
  iclass_t r_class;
  iclass_t w_dec_class;
  logic    w_dec_illegal;

  legv8_op_decode u_op_decode (
    .i_opcode  (opcode),
    .o_class   (w_dec_class),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
      r_class <= CLS_NONE;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (mem_ack) r_state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (w_dec_illegal) begin
            r_state <= ST_TRAP;
          end else begin
            r_class <= w_dec_class;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (is_rtype(r_class))                                r_state <= ST_WB;
          else if (r_class == CLS_LDUR || r_class == CLS_STUR)  r_state <= ST_MEM;
          else                                                  r_state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_ack) r_state <= (r_class == CLS_LDUR) ? ST_WB : ST_FETCH;
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  // Outputs decode the registered state/class; only the fetch and branch
  // PC pulses are qualified by the live mem_ack/rt_zero flags. Holding reset
  // forces everything low so a pending request drops immediately.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_PC4;
    alu_op     = ALU_AND;
    alu_src_b  = SRC_B_REG;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ack;
          pc_write = mem_ack;
        end
        ST_EXEC: begin
          case (r_class)
            CLS_ADD, CLS_SUB, CLS_AND, CLS_ORR: alu_op = rtype_alu_op(r_class);
            CLS_LDUR, CLS_STUR: begin
              alu_op    = ALU_ADD;
              alu_src_b = SRC_B_IMM;
            end
            CLS_CBZ: begin
              alu_op    = ALU_CBZ;
              alu_src_b = SRC_B_BR;
              pc_src    = PC_SRC_ALU;
              pc_write  = rt_zero;
            end
            CLS_CBNZ: begin
              alu_op    = ALU_CBNZ;
              alu_src_b = SRC_B_BR;
              pc_src    = PC_SRC_ALU;
              pc_write  = ~rt_zero;
            end
            CLS_B: begin
              alu_op   = ALU_B;
              pc_src   = PC_SRC_BR;
              pc_write = 1'b1;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          mem_read  = (r_class == CLS_LDUR);
          mem_write = (r_class == CLS_STUR);
        end
        ST_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_class == CLS_LDUR);
        end
        ST_TRAP: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o = r_state;

`ifdef LEGV8_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_retire_count;
  logic             w_retire;

  // Last cycle of an instruction: write-back, store ack, or any branch EXEC.
  assign w_retire = (r_state == ST_WB) ||
                    (r_state == ST_MEM && r_class == CLS_STUR && mem_ack) ||
                    (r_state == ST_EXEC && is_branch(r_class));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else if (r_state != ST_TRAP) begin
      r_cycle_count <= r_cycle_count + CNT_ONE;
      if (w_retire) r_retire_count <= r_retire_count + CNT_ONE;
    end
  end

  assign cycle_count  = r_cycle_count;
  assign retire_count = r_retire_count;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_legv8_mc_control.sv
// Scoreboarded bench for legv8_mc_control: per-instruction trace model feeds
// an expected queue that a negedge monitor drains against the DUT outputs.
module tb_legv8_mc_control;

  localparam int W = 18;
  localparam int C_ADD = 0, C_SUB = 1, C_AND = 2, C_ORR = 3, C_LDUR = 4,
                 C_STUR = 5, C_CBZ = 6, C_CBNZ = 7, C_B = 8, C_ILL = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] opcode = '0;
  logic        rt_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_read, mem_write, ir_write, pc_write, reg_write, mem_to_reg, illegal;
  logic [1:0]  pc_src, alu_src_b;
  logic [3:0]  alu_op;
  logic [2:0]  state_o;
`ifdef LEGV8_PERF_CNT_EN
  logic [31:0] cycle_count, retire_count;
`endif

  legv8_mc_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .rt_zero(rt_zero), .mem_ack(mem_ack),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state_o(state_o)
`ifdef LEGV8_PERF_CNT_EN
    , .cycle_count(cycle_count), .retire_count(retire_count)
`endif
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_cycles = 0;
  int m_retired = 0;
  logic [W-1:0] mon_act, mon_exp;

  // Field order: state, mem_read, mem_write, ir_write, pc_write, pc_src,
  // alu_op, alu_src_b, reg_write, mem_to_reg, illegal.
  function automatic logic [W-1:0] mk(input int st, input int mr, input int mw, input int irw,
                                      input int pcw, input int pcs, input int aop, input int asb,
                                      input int rw, input int m2r, input int ill);
    return {3'(st), 1'(mr), 1'(mw), 1'(irw), 1'(pcw), 2'(pcs), 4'(aop), 2'(asb),
            1'(rw), 1'(m2r), 1'(ill)};
  endfunction

  function automatic logic [W-1:0] dut_vec();
    return {state_o, mem_read, mem_write, ir_write, pc_write, pc_src, alu_op, alu_src_b,
            reg_write, mem_to_reg, illegal};
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] r11();
    return 11'($urandom_range(0, 2047));
  endfunction

  function automatic logic [10:0] gen_op(input int cls);
    case (cls)
      C_ADD:   return 11'b10001011000;
      C_SUB:   return 11'b11001011000;
      C_AND:   return 11'b10001010000;
      C_ORR:   return 11'b10101010000;
      C_LDUR:  return 11'b11111000010;
      C_STUR:  return 11'b11111000000;
      C_CBZ:   return {8'b10110100, 3'($urandom_range(0, 7))};
      C_CBNZ:  return {8'b10110101, 3'($urandom_range(0, 7))};
      C_B:     return {6'b000101, 5'($urandom_range(0, 31))};
      default: return 11'b11111111111;
    endcase
  endfunction

  // pc_src only matters while pc_write is asserted.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = dut_vec();
      if (!mon_exp[11]) begin
        mon_exp[10:9] = 2'b00;
        mon_act[10:9] = 2'b00;
      end
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL trace t=%0t actual=%05h required=%05h", $time, mon_act, mon_exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Occupies the current cycle: drive inputs, queue the expected outputs,
  // then step to just after the next rising edge.
  task automatic drive_cycle(input logic [10:0] op, input logic rz, input logic ack,
                             input logic [W-1:0] e);
    opcode  = op;
    rt_zero = rz;
    mem_ack = ack;
    exp_q.push_back(e);
    if (e[17:15] != 3'd5) m_cycles++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int cls, input int fw, input int mw, input logic rz);
    logic [10:0] op;
    logic        ld;
    op = gen_op(cls);
    for (int i = 0; i < fw; i++) drive_cycle(r11(), r1(), 1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_cycle(r11(), r1(), 1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    drive_cycle(op, r1(), r1(), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    case (cls)
      C_ADD, C_SUB, C_AND, C_ORR: begin
        drive_cycle(r11(), r1(), r1(),
                    mk(2, 0, 0, 0, 0, 0, (cls == C_ADD) ? 2 : (cls == C_SUB) ? 6 : (cls == C_ORR) ? 1 : 0,
                       0, 0, 0, 0));
        drive_cycle(r11(), r1(), r1(), mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        m_retired++;
      end
      C_LDUR, C_STUR: begin
        ld = (cls == C_LDUR);
        drive_cycle(r11(), r1(), r1(), mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
        for (int i = 0; i < mw; i++) drive_cycle(r11(), r1(), 1'b0, mk(3, ld, !ld, 0, 0, 0, 0, 0, 0, 0, 0));
        drive_cycle(r11(), r1(), 1'b1, mk(3, ld, !ld, 0, 0, 0, 0, 0, 0, 0, 0));
        if (ld) drive_cycle(r11(), r1(), r1(), mk(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        m_retired++;
      end
      C_CBZ: begin
        drive_cycle(r11(), rz, r1(), mk(2, 0, 0, 0, rz, 1, 7, 2, 0, 0, 0));
        m_retired++;
      end
      C_CBNZ: begin
        drive_cycle(r11(), rz, r1(), mk(2, 0, 0, 0, !rz, 1, 9, 2, 0, 0, 0));
        m_retired++;
      end
      C_B: begin
        drive_cycle(r11(), r1(), r1(), mk(2, 0, 0, 0, 1, 2, 8, 0, 0, 0, 0));
        m_retired++;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    mem_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_cycles  = 0;
    m_retired = 0;
  endtask

  task automatic check_counters(input string tag);
`ifdef LEGV8_PERF_CNT_EN
    chk({tag, "_cycle_count"}, cycle_count, 32'(m_cycles));
    chk({tag, "_retire_count"}, retire_count, 32'(m_retired));
`else
    chk({tag, "_model_retired_nonneg"}, 32'(m_retired >= 0), 32'd1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_outputs", 32'(dut_vec()), 32'd0);
`ifdef LEGV8_PERF_CNT_EN
    chk("reset_cycle_count", cycle_count, 32'd0);
    chk("reset_retire_count", retire_count, 32'd0);
`endif
    rst_n = 1'b1;

    // Directed: ALU, delayed load, and both compare-branches with rt_zero=1.
    run_instr(C_ADD, 0, 0, 1'b0);
    run_instr(C_LDUR, 0, 3, 1'b0);
    run_instr(C_CBZ, 0, 0, 1'b1);
    run_instr(C_CBNZ, 0, 0, 1'b1);
    run_instr(C_CBZ, 1, 0, 1'b0);
    run_instr(C_CBNZ, 2, 0, 1'b0);
    run_instr(C_B, 0, 0, 1'b0);
    run_instr(C_STUR, 0, 0, 1'b0);
    check_counters("directed");

    for (int n = 0; n < 60; n++)
      run_instr($urandom_range(C_ADD, C_B), $urandom_range(0, 3), $urandom_range(0, 3), r1());
    check_counters("random");

    // Back-to-back ADD, B, STUR with zero-wait memory from a fresh reset.
    do_reset();
    run_instr(C_ADD, 0, 0, 1'b0);
    run_instr(C_B, 0, 0, 1'b0);
    run_instr(C_STUR, 0, 0, 1'b0);
`ifdef LEGV8_PERF_CNT_EN
    chk("b2b_cycle_count", cycle_count, 32'd11);
    chk("b2b_retire_count", retire_count, 32'd3);
`endif
    check_counters("b2b");

    // Reset while a store waits in MEM.
    do_reset();
    drive_cycle(r11(), 1'b0, 1'b1, mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    drive_cycle(gen_op(C_STUR), 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive_cycle(r11(), 1'b0, 1'b0, mk(2, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0));
    drive_cycle(r11(), 1'b0, 1'b0, mk(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_state", 32'(state_o), 32'd0);
`ifdef LEGV8_PERF_CNT_EN
    chk("rst_mid_retire", retire_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    m_cycles  = 0;
    m_retired = 0;
    run_instr(C_ADD, 1, 0, 1'b0);
    check_counters("after_rst");

    // Illegal opcode: TRAP holds with illegal set until reset.
    run_instr(C_ILL, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) drive_cycle(r11(), r1(), r1(), mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    check_counters("trap");
    do_reset();
    chk("trap_exit_state", 32'(state_o), 32'd0);
    chk("trap_exit_illegal", 32'(illegal), 32'd0);
    run_instr(C_SUB, 0, 0, 1'b0);
    run_instr(C_ORR, 0, 0, 1'b0);
    run_instr(C_AND, 0, 0, 1'b0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
